load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- MEM-stage initiator that drives the byte-addressed data memory port (Mem_Addr, Write_Data, MemRead, MemWrite, funct3, Read_Data).
- Accepts one load/store request at a time from the pipeline over a valid/ready handshake.
- The memory natively handles only word (010) and doubleword (011) accesses, so this block implements byte/halfword loads by extraction and byte/halfword stores by read-modify-write.
- It also performs sign/zero extension, alignment checking and range checking, and returns the result over a valid/ready response handshake.

Parameters:
- MEM_BYTES, 64, size of data memory in bytes; any access with addr+size > MEM_BYTES faults.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV64 funct3. Loads: 000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu. Stores: 000 sb, 001 sh, 010 sw, 011 sd.
- req_addr  in  64  byte address.
- req_wdata  in  64  store data; low bytes used.
- resp_valid  out  1  response present.
- resp_ready  in  1  pipeline accepts response.
- resp_rdata  out  64  extended load data; 0 for stores and faults.
- resp_fault  out  1  misaligned, out-of-range or illegal funct3.
- Mem_Addr  out  64  memory address.
- Write_Data  out  64  memory write data.
- MemRead  out  1  memory read enable.
- MemWrite  out  1  memory write enable; the write commits at the clk edge.
- funct3  out  3  memory access size: 010 word, 011 doubleword.
- Read_Data  in  64  memory read data, combinational from Mem_Addr/funct3/MemRead.

Behaviour:
- Reset (rst_n low, async): state = IDLE; all latched registers = 0.
  - resp_valid = 0, resp_rdata = 0, resp_fault = 0.
  - MemRead = 0, MemWrite = 0, Mem_Addr = 0, Write_Data = 0, funct3 = 0.
- States: IDLE, READ, RMW_READ, WRITE, RESP.
- Memory-side outputs are combinational from state and latched registers. They are all 0 in IDLE and RESP.
- IDLE: req_ready = 1. On an edge with req_valid = 1, latch store/funct3/addr/wdata and evaluate the fault condition:
  - any fault -> RESP with fault = 1; no memory access.
  - load -> READ.
  - sw or sd -> WRITE.
  - sb or sh -> RMW_READ.
- Fault conditions:
  - illegal funct3: load 111, or store 1xx.
  - lh/lhu/sh with addr[1:0] = 11.
  - lw/lwu/sw with addr[1:0] != 00.
  - ld/sd with addr[2:0] != 000.
  - addr + size > MEM_BYTES, computed in 65-bit arithmetic so wrap cannot hide a fault.
- READ: MemRead = 1.
  - Mem_Addr = addr with [1:0] cleared, funct3 = 010, for all loads except ld.
  - Mem_Addr = addr, funct3 = 011, for ld.
  - At the edge, extract the byte or halfword at offset addr[1:0], sign- or zero-extend per the load funct3, register into resp_rdata, go to RESP.
- RMW_READ: MemRead = 1, Mem_Addr = addr with [1:0] cleared, funct3 = 010. At the edge, latch the word with req_wdata[7:0] or [15:0] merged at offset addr[1:0]; go to WRITE.
- WRITE: MemWrite = 1; funct3 = 011 for sd, 010 otherwise.
  - sb/sh: Mem_Addr = aligned address, Write_Data = {32'd0, merged word}.
  - sw/sd: Mem_Addr = addr, Write_Data = wdata.
  - Go to RESP at the edge.
  - MemWrite is high for exactly one cycle per store.
- RESP: resp_valid = 1; resp_rdata and resp_fault are held stable until an edge with resp_ready = 1, then go to IDLE.
  - req_ready = 0, so a new request cannot be accepted in the same cycle the response is consumed.
- Latency, counted in edges from accept to resp_valid first high:
  - load: 2.
  - sw/sd: 2.
  - sb/sh: 3.
  - fault: 1.
- Reset mid-operation: immediate return to IDLE.
  - A store aborted in RMW_READ or WRITE before its commit edge writes nothing; MemWrite drops combinationally.
  - A pending response is discarded.
- Back-to-back throughput: one request per (latency + 1) cycles minimum.

Test Plan:
- Memory bytes 0..7 = EB 12 78 4F 48 B6 45 FE.
  - lb @0 -> FFFFFFFFFFFFFFEB; lbu @0 -> 00000000000000EB.
  - lh @4 -> FFFFFFFFFFFFB648; lhu @2 -> 0000000000004F78.
  - Each load: MemRead high exactly 1 cycle, resp 2 edges after accept.
- lw @4 -> FFFFFFFFFE45B648; lwu @4 -> 00000000FE45B648; ld @0 -> FE45B6484F7812EB with funct3 = 011 on the port.
- sb @5 wdata 0x..AA:
  - word read @4, one MemWrite with Mem_Addr = 4, Write_Data = 00000000FE45AA48.
  - resp after 3 edges, fault = 0.
  - A following ld @0 -> FE45AA484F7812EB.
- Faults produce resp_fault = 1 and resp_rdata = 0 after 1 edge, with MemRead and MemWrite never asserted:
  - lw @2.
  - sh @7.
  - ld @60 (MEM_BYTES = 64).
  - load funct3 111.
  - sd @0xFFFFFFFFFFFFFFF8 (wrap case).
- Backpressure: hold resp_ready = 0 for 3 cycles after resp_valid rises.
  - resp_valid, resp_rdata and resp_fault stay stable.
  - req_ready stays 0; a req_valid presented meanwhile is not accepted until after the resp_ready handshake.
- Assert rst_n low during the WRITE cycle of sw @8 wdata 12345678.
  - MemWrite drops immediately; bytes 8..11 are unchanged.
  - All outputs return to reset values; a request accepted after release completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage initiator for a word/doubleword-only data memory.
// Byte and halfword loads are extracted from a word read; byte and halfword
// stores are done as a word read-modify-write. Alignment, range and funct3
// legality are checked at accept time, so a faulting request never touches
// the memory port.
module load_store_unit #(
    parameter int MEM_BYTES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    // Request handshake
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    // Response handshake
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_fault,
    // Data memory port
    output logic [63:0] Mem_Addr,
    output logic [63:0] Write_Data,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [2:0]  funct3,
    input  logic [63:0] Read_Data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_RMW_READ,
        S_WRITE,
        S_RESP
    } state_t;

    localparam logic [64:0] LP_MEM_END = 65'(MEM_BYTES);

    state_t      r_state;
    logic        r_store;
    logic [2:0]  r_funct3;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;
    logic [31:0] r_merged;
    logic [63:0] r_rdata;
    logic        r_fault;

    // Accept-time fault evaluation on the raw request
    logic [3:0]  w_size;
    logic [64:0] w_end;
    logic        w_illegal;
    logic        w_misalign;
    logic        w_range;
    logic        w_fault;

    assign w_size    = 4'd1 << req_funct3[1:0];
    // A 65-bit sum keeps a wrap past 2^64 visible to the range compare.
    assign w_end     = {1'b0, req_addr} + {61'd0, w_size};
    assign w_range   = w_end > LP_MEM_END;
    assign w_illegal = req_store ? req_funct3[2] : (req_funct3 == 3'b111);
    assign w_fault   = w_illegal | w_misalign | w_range;

    // Alignment requirement depends only on access size
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_misalign = 1'b0;
        case (req_funct3[1:0])
            2'b01:   w_misalign = &req_addr[1:0];
            2'b10:   w_misalign = |req_addr[1:0];
            2'b11:   w_misalign = |req_addr[2:0];
            default: w_misalign = 1'b0;
        endcase
    end

    // Datapath helpers derived from latched request
    logic        w_is_dw;
    logic [63:0] w_aligned;
    logic [4:0]  w_shamt;
    logic [31:0] w_lane;
    logic [31:0] w_mask;
    logic [31:0] w_ins;
    logic [31:0] w_merged;
    logic [63:0] w_load_data;

    assign w_is_dw   = (r_funct3 == 3'b011);
    assign w_aligned = {r_addr[63:2], 2'b00};
    assign w_shamt   = {r_addr[1:0], 3'b000};
    assign w_lane    = Read_Data[31:0] >> w_shamt;
    assign w_mask    = (r_funct3[0] ? 32'h0000_FFFF : 32'h0000_00FF) << w_shamt;
    assign w_ins     = {16'd0, r_wdata[15:0]} << w_shamt;
    assign w_merged  = (Read_Data[31:0] & ~w_mask) | (w_ins & w_mask);

    // Sign/zero extension of the addressed lane per load funct3
    always_comb begin
        w_load_data = 64'd0;
        case (r_funct3)
            3'b000:  w_load_data = {{56{w_lane[7]}}, w_lane[7:0]};
            3'b001:  w_load_data = {{48{w_lane[15]}}, w_lane[15:0]};
            3'b010:  w_load_data = {{32{w_lane[31]}}, w_lane};
            3'b011:  w_load_data = Read_Data;
            3'b100:  w_load_data = {56'd0, w_lane[7:0]};
            3'b101:  w_load_data = {48'd0, w_lane[15:0]};
            3'b110:  w_load_data = {32'd0, w_lane};
            default: w_load_data = 64'd0;
        endcase
    end

    // Control FSM: request latch, memory sequencing and response hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_store  <= 1'b0;
            r_funct3 <= 3'd0;
            r_addr   <= 64'd0;
            r_wdata  <= 64'd0;
            r_merged <= 32'd0;
            r_rdata  <= 64'd0;
            r_fault  <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_store  <= req_store;
                        r_funct3 <= req_funct3;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        r_rdata  <= 64'd0;
                        r_fault  <= w_fault;
                        if (w_fault)                 r_state <= S_RESP;
                        else if (!req_store)         r_state <= S_READ;
                        else if (req_funct3[1])      r_state <= S_WRITE;
                        else                         r_state <= S_RMW_READ;
                    end
                end
                S_READ: begin
                    r_rdata <= w_load_data;
                    r_state <= S_RESP;
                end
                S_RMW_READ: begin
                    r_merged <= w_merged;
                    r_state  <= S_WRITE;
                end
                S_WRITE: begin
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_rdata <= 64'd0;
                        r_fault <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Memory-port drive, decoded from state; idle in IDLE and RESP
    always_comb begin
        Mem_Addr   = 64'd0;
        Write_Data = 64'd0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        funct3     = 3'd0;
        case (r_state)
            S_READ: begin
                MemRead  = 1'b1;
                Mem_Addr = w_is_dw ? r_addr : w_aligned;
                funct3   = w_is_dw ? 3'b011 : 3'b010;
            end
            S_RMW_READ: begin
                MemRead  = 1'b1;
                Mem_Addr = w_aligned;
                funct3   = 3'b010;
            end
            S_WRITE: begin
                MemWrite = 1'b1;
                funct3   = w_is_dw ? 3'b011 : 3'b010;
                if (r_funct3[1]) begin
                    Mem_Addr   = r_addr;
                    Write_Data = r_wdata;
                end else begin
                    Mem_Addr   = w_aligned;
                    Write_Data = {32'd0, r_merged};
                end
            end
            default: ;
        endcase
    end

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = (r_state == S_RESP);
    assign resp_rdata = r_rdata;
    assign resp_fault = r_fault;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vectors against a byte-array memory model.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_fault;
    logic [63:0] Mem_Addr;
    logic [63:0] Write_Data;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  funct3;
    logic [63:0] Read_Data;

    load_store_unit #(.MEM_BYTES(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_fault(resp_fault),
        .Mem_Addr(Mem_Addr), .Write_Data(Write_Data), .MemRead(MemRead),
        .MemWrite(MemWrite), .funct3(funct3), .Read_Data(Read_Data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: 64 bytes, combinational read, write at the clock edge
    logic [7:0] mem [0:63];
    logic       mem_load;

    always_comb begin
        Read_Data = 64'd0;
        if (MemRead && Mem_Addr < 64) begin
            for (int b = 0; b < 8; b++) begin
                if ((b < 4 || funct3 == 3'b011) && (int'(Mem_Addr[6:0]) + b) < 64)
                    Read_Data[b*8 +: 8] = mem[int'(Mem_Addr[6:0]) + b];
            end
        end
    end

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 64; i++) mem[i] <= 8'(i * 3 + 1);
            mem[0] <= 8'hEB; mem[1] <= 8'h12; mem[2] <= 8'h78; mem[3] <= 8'h4F;
            mem[4] <= 8'h48; mem[5] <= 8'hB6; mem[6] <= 8'h45; mem[7] <= 8'hFE;
        end else if (MemWrite && Mem_Addr < 64) begin
            for (int b = 0; b < 8; b++) begin
                if ((b < 4 || funct3 == 3'b011) && (int'(Mem_Addr[6:0]) + b) < 64)
                    mem[int'(Mem_Addr[6:0]) + b] <= Write_Data[b*8 +: 8];
            end
        end
    end

    // Port monitor: running totals of memory strobes and last transfer seen
    int          rd_total = 0;
    int          wr_total = 0;
    logic [2:0]  last_rd_f3 = 3'd0;
    logic [63:0] last_wr_addr = 64'd0;
    logic [63:0] last_wr_data = 64'd0;

    always @(posedge clk) begin
        if (MemRead) begin
            rd_total   <= rd_total + 1;
            last_rd_f3 <= funct3;
        end
        if (MemWrite) begin
            wr_total     <= wr_total + 1;
            last_wr_addr <= Mem_Addr;
            last_wr_data <= Write_Data;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One full request/response; called #1 after a rising edge with the DUT idle
    task automatic run_req(input string tag, input logic st, input logic [2:0] f3,
                           input logic [63:0] addr, input logic [63:0] wd,
                           input int exp_lat, input logic [63:0] exp_rd,
                           input logic exp_flt, input int exp_nrd, input int exp_nwr);
        int rd0, wr0, lat;
        rd0 = rd_total;
        wr0 = wr_total;
        check({tag, " req_ready"}, 64'(req_ready), 64'd1);
        req_store  = st;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        req_valid  = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " rdata"}, resp_rdata, exp_rd);
        check({tag, " fault"}, 64'(resp_fault), 64'(exp_flt));
        check({tag, " reads"}, 64'(rd_total - rd0), 64'(exp_nrd));
        check({tag, " writes"}, 64'(wr_total - wr0), 64'(exp_nwr));
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    logic [63:0] held;
    int          wr_before;

    initial begin
        rst_n      = 1'b0;
        mem_load   = 1'b1;
        req_valid  = 1'b0;
        req_store  = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 64'd0;
        req_wdata  = 64'd0;
        resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst resp_valid", 64'(resp_valid), 64'd0);
        check("rst resp_rdata", resp_rdata, 64'd0);
        check("rst resp_fault", 64'(resp_fault), 64'd0);
        check("rst MemRead", 64'(MemRead), 64'd0);
        check("rst MemWrite", 64'(MemWrite), 64'd0);
        check("rst Mem_Addr", Mem_Addr, 64'd0);
        check("rst Write_Data", Write_Data, 64'd0);
        check("rst funct3", 64'(funct3), 64'd0);
        check("rst req_ready", 64'(req_ready), 64'd1);
        mem_load = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk); #1;

        // Loads from the preset bytes EB 12 78 4F 48 B6 45 FE
        run_req("lb@0",  1'b0, 3'b000, 64'd0, 64'd0, 2, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 1, 0);
        run_req("lbu@0", 1'b0, 3'b100, 64'd0, 64'd0, 2, 64'h0000_0000_0000_00EB, 1'b0, 1, 0);
        run_req("lh@4",  1'b0, 3'b001, 64'd4, 64'd0, 2, 64'hFFFF_FFFF_FFFF_B648, 1'b0, 1, 0);
        run_req("lhu@2", 1'b0, 3'b101, 64'd2, 64'd0, 2, 64'h0000_0000_0000_4F78, 1'b0, 1, 0);
        run_req("lw@4",  1'b0, 3'b010, 64'd4, 64'd0, 2, 64'hFFFF_FFFF_FE45_B648, 1'b0, 1, 0);
        run_req("lwu@4", 1'b0, 3'b110, 64'd4, 64'd0, 2, 64'h0000_0000_FE45_B648, 1'b0, 1, 0);
        run_req("ld@0",  1'b0, 3'b011, 64'd0, 64'd0, 2, 64'hFE45_B648_4F78_12EB, 1'b0, 1, 0);
        check("ld@0 port funct3", 64'(last_rd_f3), 64'd3);
        // Last legal bytes of memory
        run_req("ld@56",  1'b0, 3'b011, 64'd56, 64'd0, 2, 64'hBEBB_B8B5_B2AF_ACA9, 1'b0, 1, 0);
        run_req("lbu@63", 1'b0, 3'b100, 64'd63, 64'd0, 2, 64'h0000_0000_0000_00BE, 1'b0, 1, 0);

        // Sub-word stores via read-modify-write
        run_req("sb@5", 1'b1, 3'b000, 64'd5, 64'h1111_2222_3333_44AA, 3, 64'd0, 1'b0, 1, 1);
        check("sb@5 wr addr", last_wr_addr, 64'd4);
        check("sb@5 wr data", last_wr_data, 64'h0000_0000_FE45_AA48);
        run_req("ld@0 after sb", 1'b0, 3'b011, 64'd0, 64'd0, 2, 64'hFE45_AA48_4F78_12EB, 1'b0, 1, 0);
        run_req("sh@14", 1'b1, 3'b001, 64'd14, 64'h0000_0000_0000_BEEF, 3, 64'd0, 1'b0, 1, 1);
        check("sh@14 wr addr", last_wr_addr, 64'd12);
        check("sh@14 wr data", last_wr_data, 64'h0000_0000_BEEF_2825);
        run_req("lw@12", 1'b0, 3'b010, 64'd12, 64'd0, 2, 64'hFFFF_FFFF_BEEF_2825, 1'b0, 1, 0);

        // Full-word store goes straight to WRITE
        run_req("sw@16", 1'b1, 3'b010, 64'd16, 64'hDEAD_BEEF_CAFE_F00D, 2, 64'd0, 1'b0, 0, 1);
        check("sw@16 wr addr", last_wr_addr, 64'd16);
        check("sw@16 wr data", last_wr_data, 64'hDEAD_BEEF_CAFE_F00D);
        run_req("lwu@16", 1'b0, 3'b110, 64'd16, 64'd0, 2, 64'h0000_0000_CAFE_F00D, 1'b0, 1, 0);

        // Faults: one edge, no memory traffic
        run_req("flt lw@2",   1'b0, 3'b010, 64'd2,  64'd0, 1, 64'd0, 1'b1, 0, 0);
        run_req("flt sh@7",   1'b1, 3'b001, 64'd7,  64'd0, 1, 64'd0, 1'b1, 0, 0);
        run_req("flt ld@60",  1'b0, 3'b011, 64'd60, 64'd0, 1, 64'd0, 1'b1, 0, 0);
        run_req("flt ld3@64", 1'b0, 3'b000, 64'd64, 64'd0, 1, 64'd0, 1'b1, 0, 0);
        run_req("flt f3=111", 1'b0, 3'b111, 64'd0,  64'd0, 1, 64'd0, 1'b1, 0, 0);
        run_req("flt st 1xx", 1'b1, 3'b100, 64'd0,  64'd0, 1, 64'd0, 1'b1, 0, 0);
        run_req("flt sd wrap", 1'b1, 3'b011, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 1, 64'd0, 1'b1, 0, 0);

        // Backpressure: response held while a new request waits
        req_store  = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 64'd4;
        req_valid  = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("bp resp_valid", 64'(resp_valid), 64'd1);
        held = 64'hFFFF_FFFF_FE45_AA48;
        req_funct3 = 3'b100;
        req_addr   = 64'd0;
        req_valid  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check("bp hold valid", 64'(resp_valid), 64'd1);
            check("bp hold rdata", resp_rdata, held);
            check("bp hold fault", 64'(resp_fault), 64'd0);
            check("bp hold req_ready", 64'(req_ready), 64'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("bp after hs valid", 64'(resp_valid), 64'd0);
        check("bp after hs req_ready", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("bp second accepted", 64'(MemRead), 64'd1);
        @(posedge clk); #1;
        check("bp second valid", 64'(resp_valid), 64'd1);
        check("bp second rdata", resp_rdata, 64'h0000_0000_0000_00EB);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;

        // Reset during the WRITE cycle of sw@8
        wr_before  = wr_total;
        req_store  = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 64'd8;
        req_wdata  = 64'h0000_0000_1234_5678;
        req_valid  = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("abort MemWrite before", 64'(MemWrite), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort MemWrite", 64'(MemWrite), 64'd0);
        check("abort Mem_Addr", Mem_Addr, 64'd0);
        check("abort Write_Data", Write_Data, 64'd0);
        check("abort funct3", 64'(funct3), 64'd0);
        check("abort resp_valid", 64'(resp_valid), 64'd0);
        check("abort req_ready", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort no write", 64'(wr_total - wr_before), 64'd0);
        @(posedge clk); #1;
        run_req("lw@8 after abort", 1'b0, 3'b010, 64'd8, 64'd0, 2, 64'h0000_0000_221F_1C19, 1'b0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
